// File: rtl/xc_malu_pkg.sv
// Shared types and op-decode helpers for the XCrypto multiply/divide unit.
package xc_malu_pkg;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7,
    OP_CLMUL  = 4'd8,
    OP_CLMULH = 4'd9,
    OP_CLMULR = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Integer multiplies occupy codes 0..3.
  function automatic logic is_mul(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

  // Divides and remainders occupy codes 4..7; op[1] selects remainder.
  function automatic logic is_div(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

  function automatic logic is_clmul(input logic [3:0] op);
    return (op == OP_CLMUL) || (op == OP_CLMULH) || (op == OP_CLMULR);
  endfunction

  function automatic logic is_signed_lhs(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_rhs(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Ops that return the upper half of the double-width product.
  function automatic logic sel_high(input logic [3:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) || (op == OP_CLMULH);
  endfunction

endpackage

// File: rtl/xc_malu_mdr_step.sv
// One cycle of the multi-cycle datapath: BPC shift-add, shift-xor or
// restoring-divide iterations on the accumulator and partial remainder.
// Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
// Divide:   acc low half holds dividend bits shifting out / quotient bits in.
module xc_malu_mdr_step
  import xc_malu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1,
  parameter int CW   = 6
) (
  input  logic                div_mode,
  input  logic                clmul_mode,
  input  logic [XLEN-1:0]     opd,
  input  logic [2*XLEN-1:0]   acc_in,
  input  logic [XLEN:0]       pr_in,
  input  logic [CW-1:0]       cnt_in,
  output logic [2*XLEN-1:0]   acc_out,
  output logic [XLEN:0]       pr_out,
  output logic [CW-1:0]       cnt_out
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     pr;
  logic [XLEN:0]     pr_sh;
  logic [XLEN+1:0]   diff;
  logic [XLEN:0]     sum;

  // Unrolled BPC iterations; each iteration sees the previous one's result.
  always_comb begin
    acc   = acc_in;
    pr    = pr_in;
    pr_sh = '0;
    diff  = '0;
    sum   = '0;
    for (int i = 0; i < BPC; i++) begin
      if (div_mode) begin
        pr_sh = {pr[XLEN-1:0], acc[XLEN-1]};
        diff  = {pr[XLEN], pr_sh} - {2'b00, opd};
        if (!diff[XLEN+1]) begin
          pr             = diff[XLEN:0];
          acc[XLEN-1:0]  = {acc[XLEN-2:0], 1'b1};
        end else begin
          pr             = pr_sh;
          acc[XLEN-1:0]  = {acc[XLEN-2:0], 1'b0};
        end
      end else if (clmul_mode) begin
        sum = {1'b0, acc[2*XLEN-1:XLEN] ^ (acc[0] ? opd : '0)};
        acc = {sum, acc[XLEN-1:1]};
      end else begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opd : '0)};
        acc = {sum, acc[XLEN-1:1]};
      end
    end
    acc_out = acc;
    pr_out  = pr;
    cnt_out = cnt_in + {{(CW-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/xc_malu_mdr_p.sv
// Multi-cycle multiply / divide / carry-less multiply unit.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready. in_ready is high only in IDLE,
// out_valid only in DONE, and result is forced to 0 whenever out_valid is low.
module xc_malu_mdr_p
  import xc_malu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output state_t          dbg_state
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic              sa_q, sb_q, dz_q, ov_q;
  logic [XLEN-1:0]   opd_q, res_q;
  logic [2*XLEN-1:0] acc_q, acc_nx, prod;
  logic [XLEN:0]     pr_q, pr_nx;
  logic [CW-1:0]     cnt_q, cnt_nx;
  logic              accept, sa_in, sb_in, div_in;
  logic [XLEN-1:0]   mag1, mag2, quo, rem, fix_res;

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_CALC;
      end
      ST_CALC: if (cnt_q == LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  assign accept    = in_valid && in_ready && !flush;
  assign result    = out_valid ? res_q : '0;
  assign dbg_state = state_q;

  // Operand magnitudes and sign flags captured at accept.
  always_comb begin
    sa_in  = is_signed_lhs(op) && rs1[XLEN-1];
    sb_in  = is_signed_rhs(op) && rs2[XLEN-1];
    mag1   = sa_in ? -rs1 : rs1;
    mag2   = sb_in ? -rs2 : rs2;
    div_in = is_div(op);
  end

  xc_malu_mdr_step #(.XLEN(XLEN), .BPC(BPC), .CW(CW)) u_step (
    .div_mode   (is_div(op_q)),
    .clmul_mode (is_clmul(op_q)),
    .opd        (opd_q),
    .acc_in     (acc_q),
    .pr_in      (pr_q),
    .cnt_in     (cnt_q),
    .acc_out    (acc_nx),
    .pr_out     (pr_nx),
    .cnt_out    (cnt_nx)
  );

  // Sign fix-up, word select and divide corner cases for the FIX cycle.
  // Divide by zero leaves the dividend magnitude in the partial remainder,
  // so the ordinary remainder sign fix already yields rs1.
  always_comb begin
    prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo     = acc_q[XLEN-1:0];
    rem     = pr_q[XLEN-1:0];
    fix_res = '0;
    if (is_mul(op_q)) begin
      fix_res = sel_high(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end else if (is_div(op_q)) begin
      if (op_q[1]) begin
        if (ov_q)      fix_res = '0;
        else           fix_res = sa_q ? -rem : rem;
      end else begin
        if (dz_q)      fix_res = '1;
        else if (ov_q) fix_res = {1'b1, {(XLEN-1){1'b0}}};
        else           fix_res = (sa_q ^ sb_q) ? -quo : quo;
      end
    end else if (op_q == OP_CLMUL) begin
      fix_res = acc_q[XLEN-1:0];
    end else if (op_q == OP_CLMULH) begin
      fix_res = acc_q[2*XLEN-1:XLEN];
    end else if (op_q == OP_CLMULR) begin
      fix_res = acc_q[2*XLEN-2:XLEN-1];
    end
  end

  // State, datapath and result registers.
  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      pr_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op;
        sa_q  <= sa_in;
        sb_q  <= sb_in;
        dz_q  <= div_in && (rs2 == '0);
        ov_q  <= div_in && is_signed_lhs(op) &&
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        opd_q <= div_in ? mag2 : mag1;
        acc_q <= {{XLEN{1'b0}}, (div_in ? mag1 : mag2)};
        pr_q  <= '0;
        cnt_q <= '0;
      end else if (state_q == ST_CALC) begin
        acc_q <= acc_nx;
        pr_q  <= pr_nx;
        cnt_q <= cnt_nx;
      end else if (state_q == ST_FIX) begin
        res_q <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_xc_malu_mdr_p.sv
// Bench for xc_malu_mdr_p: three instances (32/1, 32/4, 64/2) checked
// against an arithmetic reference model plus directed corner cases.
module tb_xc_malu_mdr_p;
  import xc_malu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic resetn;

  logic [2:0]  flush, in_valid, out_ready, in_ready, out_valid;
  logic [3:0]  op  [3];
  logic [63:0] rs1 [3];
  logic [63:0] rs2 [3];
  logic [31:0] res0, res1;
  logic [63:0] res2;
  state_t      st0, st1, st2;

  int n_cmp = 0;
  int n_bad = 0;

  xc_malu_mdr_p #(.XLEN(32), .BPC(1)) u0 (
    .clock(clock), .resetn(resetn), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .op(op[0]), .rs1(rs1[0][31:0]), .rs2(rs2[0][31:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res0), .dbg_state(st0));

  xc_malu_mdr_p #(.XLEN(32), .BPC(4)) u1 (
    .clock(clock), .resetn(resetn), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .op(op[1]), .rs1(rs1[1][31:0]), .rs2(rs2[1][31:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res1), .dbg_state(st1));

  xc_malu_mdr_p #(.XLEN(64), .BPC(2)) u2 (
    .clock(clock), .resetn(resetn), .flush(flush[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .op(op[2]), .rs1(rs1[2]), .rs2(rs2[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(res2), .dbg_state(st2));

  function automatic logic [63:0] res(input int u);
    case (u)
      0: return {32'h0, res0};
      1: return {32'h0, res1};
      default: return res2;
    endcase
  endfunction

  function automatic state_t st(input int u);
    case (u)
      0: return st0;
      1: return st1;
      default: return st2;
    endcase
  endfunction

  function automatic int xl(input int u);
    return (u == 2) ? 64 : 32;
  endfunction

  function automatic int nlat(input int u);
    int bpc;
    bpc = (u == 0) ? 1 : ((u == 1) ? 4 : 2);
    return xl(u) / bpc + 2;
  endfunction

  function automatic logic [63:0] mask_of(input int x);
    return (x == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a_in,
                                         input logic [63:0] b_in, input int x);
    logic [63:0]         m, a, b, minv;
    logic signed [127:0] sa, sb, ua, ub, p;
    logic [127:0]        c, t;
    m    = mask_of(x);
    a    = a_in & m;
    b    = b_in & m;
    minv = (x == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (x == 64) begin
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
    end else begin
      sa = {{96{a[31]}}, a[31:0]};
      sb = {{96{b[31]}}, b[31:0]};
    end
    ua = {64'h0, a};
    ub = {64'h0, b};
    c  = '0;
    for (int i = 0; i < x; i++)
      if (b[i]) c = c ^ (ua << i);
    p = '0;
    case (o)
      4'd0: begin p = sa * sb; return p[63:0] & m; end
      4'd1: begin p = sa * sb; t = p >> x; return t[63:0] & m; end
      4'd2: begin p = sa * ub; t = p >> x; return t[63:0] & m; end
      4'd3: begin p = ua * ub; t = p >> x; return t[63:0] & m; end
      4'd4: begin
        if (b == 0) return m;
        if (a == minv && b == m) return minv;
        p = sa / sb; return p[63:0] & m;
      end
      4'd5: begin
        if (b == 0) return m;
        p = ua / ub; return p[63:0] & m;
      end
      4'd6: begin
        if (b == 0) return a;
        if (a == minv && b == m) return 64'h0;
        p = sa % sb; return p[63:0] & m;
      end
      4'd7: begin
        if (b == 0) return a;
        p = ua % ub; return p[63:0] & m;
      end
      4'd8:  return c[63:0] & m;
      4'd9:  begin t = c >> x; return t[63:0] & m; end
      4'd10: begin t = c >> (x - 1); return t[63:0] & m; end
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] pick(input int x);
    logic [63:0] m;
    m = mask_of(x);
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return m;
      2: return (x == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      3: return 64'h1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Starts and ends at a negedge with the unit in IDLE. Garbage is driven on
  // the inputs while busy; it must be ignored.
  task automatic run_op(input int u, input logic [3:0] o, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] r, output int lat);
    n_cmp++;
    if (in_ready[u] !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_ready u%0d: in_ready=%b required 1", u, in_ready[u]);
    end
    op[u] = o; rs1[u] = a; rs2[u] = b; in_valid[u] = 1'b1; out_ready[u] = 1'b0;
    @(posedge clock); lat = 1;
    @(negedge clock);
    while (out_valid[u] !== 1'b1 && lat < 300) begin
      in_valid[u] = 1'($urandom_range(0, 1));
      op[u]  = 4'($urandom);
      rs1[u] = {$urandom, $urandom};
      rs2[u] = {$urandom, $urandom};
      @(posedge clock); lat++;
      @(negedge clock);
    end
    in_valid[u] = 1'b0;
    n_cmp++;
    if (out_valid[u] !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout u%0d: out_valid=%b after %0d cycles, required 1", u, out_valid[u], lat);
    end
    r = res(u);
    out_ready[u] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready[u] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; flush = '0; in_valid = '0; out_ready = '0;
    for (int u = 0; u < 3; u++) begin
      op[u] = '0; rs1[u] = '0; rs2[u] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock); resetn = 1'b1;
    @(negedge clock);
    for (int u = 0; u < 3; u++) begin
      n_cmp++;
      if (in_ready[u] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready u%0d: got %b required 1", u, in_ready[u]); end
      n_cmp++;
      if (out_valid[u] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid u%0d: got %b required 0", u, out_valid[u]); end
      n_cmp++;
      if (res(u) !== 64'h0) begin n_bad++; $display("FAIL reset_result u%0d: got %h required 0", u, res(u)); end
      n_cmp++;
      if (st(u) !== ST_IDLE) begin n_bad++; $display("FAIL reset_state u%0d: got %0d required %0d", u, st(u), ST_IDLE); end
    end
  endtask

  task automatic test_directed();
    logic [3:0]  t_op [14];
    logic [31:0] t_a  [14];
    logic [31:0] t_b  [14];
    logic [31:0] t_e  [14];
    logic [63:0] r;
    int lat;
    t_op = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd4, 4'd6, 4'd5, 4'd7, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
    t_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
             32'h80000000, 32'h80000000, 32'd7, 32'd7, 32'd0, 32'h3, 32'h80000000,
             32'h80000000, 32'h12345678};
    t_b  = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'h0, 32'h0, 32'h0, 32'h3, 32'h2, 32'h2, 32'h9};
    t_e  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF,
             32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF,
             32'h5, 32'h1, 32'h2, 32'h0};
    for (int i = 0; i < 14; i++) begin
      run_op(0, t_op[i], {32'h0, t_a[i]}, {32'h0, t_b[i]}, r, lat);
      n_cmp++;
      if (r[31:0] !== t_e[i]) begin
        n_bad++;
        $display("FAIL directed[%0d] op=%0d: got %h required %h", i, t_op[i], r[31:0], t_e[i]);
      end
      n_cmp++;
      if (lat != 34) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got %0d required 34", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    int lat;
    e = model(4'd1, 64'h12345678, 64'h9ABCDEF0, 32);
    op[0] = 4'd1; rs1[0] = 64'h12345678; rs2[0] = 64'h9ABCDEF0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clock); lat = 1;
    @(negedge clock); in_valid[0] = 1'b0;
    while (out_valid[0] !== 1'b1 && lat < 300) begin
      @(posedge clock); lat++; @(negedge clock);
    end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (out_valid[0] !== 1'b1 || res(0) !== e || in_ready[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: valid=%b result=%h in_ready=%b required 1/%h/0",
                 k, out_valid[0], res(0), in_ready[0], e);
      end
      @(posedge clock); @(negedge clock);
    end
    out_ready[0] = 1'b1;
    @(posedge clock); @(negedge clock);
    out_ready[0] = 1'b0;
    n_cmp++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || res(0) !== 64'h0) begin
      n_bad++;
      $display("FAIL backpressure_release: in_ready=%b valid=%b result=%h required 1/0/0",
               in_ready[0], out_valid[0], res(0));
    end
  endtask

  task automatic test_flush();
    int seen;
    // flush while CALC counter == 5
    op[0] = 4'd4; rs1[0] = 64'd1000; rs2[0] = 64'd7; in_valid[0] = 1'b1;
    @(posedge clock);
    @(negedge clock); in_valid[0] = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock); flush[0] = 1'b1;
    @(posedge clock);
    @(negedge clock); flush[0] = 1'b0;
    n_cmp++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_calc: in_ready=%b valid=%b required 1/0", in_ready[0], out_valid[0]);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); @(negedge clock);
      if (out_valid[0] === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL flush_no_result: out_valid seen %0d cycles required 0", seen); end
    // flush beats a coincident input accept in IDLE
    in_valid[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clock);
    @(negedge clock); in_valid[0] = 1'b0; flush[0] = 1'b0;
    n_cmp++;
    if (st(0) !== ST_IDLE || in_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_vs_accept: state=%0d in_ready=%b required IDLE/1", st(0), in_ready[0]);
    end
    // flush beats a coincident output handshake in DONE
    op[0] = 4'd0; rs1[0] = 64'd3; rs2[0] = 64'd5; in_valid[0] = 1'b1;
    @(posedge clock);
    @(negedge clock); in_valid[0] = 1'b0;
    for (int k = 0; k < 300 && out_valid[0] !== 1'b1; k++) begin
      @(posedge clock); @(negedge clock);
    end
    flush[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock); flush[0] = 1'b0; out_ready[0] = 1'b0;
    n_cmp++;
    if (out_valid[0] !== 1'b0 || res(0) !== 64'h0 || st(0) !== ST_IDLE) begin
      n_bad++;
      $display("FAIL flush_done: valid=%b result=%h state=%0d required 0/0/IDLE",
               out_valid[0], res(0), st(0));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int lat;
    run_op(1, 4'd4, 64'hFFFF_FF00, 64'h10, r, lat);
    n_cmp++;
    if (r[31:0] !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL b2b_first: got %h required fffffff0", r[31:0]); end
    n_cmp++;
    if (out_valid[1] !== 1'b0 || res(1) !== 64'h0) begin
      n_bad++;
      $display("FAIL b2b_idle: valid=%b result=%h required 0/0", out_valid[1], res(1));
    end
    run_op(1, 4'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, lat);
    n_cmp++;
    if (r[31:0] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL b2b_second: got %h required fffffffe", r[31:0]); end
    n_cmp++;
    if (lat != 10) begin n_bad++; $display("FAIL b2b_latency: got %0d required 10", lat); end
  endtask

  task automatic test_random(input int u, input int count);
    logic [3:0]  o;
    logic [63:0] a, b, r, e;
    int lat;
    for (int i = 0; i < count; i++) begin
      o = 4'($urandom_range(0, 11));
      a = pick(xl(u));
      b = pick(xl(u));
      e = model(o, a, b, xl(u));
      run_op(u, o, a, b, r, lat);
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL random u%0d op=%0d a=%h b=%h: got %h required %h", u, o, a, b, r, e);
      end
      n_cmp++;
      if (lat != nlat(u)) begin
        n_bad++;
        $display("FAIL random_latency u%0d: got %0d required %0d", u, lat, nlat(u));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random(0, 30);
    test_random(1, 60);
    test_random(2, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
